datapath_mc: RTL

//  Parametrised, multi-cycle successor to the single-bus CPU datapath.

---
 rtl/datapath_mc.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/datapath_mc.sv
// Multi-cycle single-bus CPU datapath: register file, special registers, Z,
// a single-cycle ALU and an iterative signed MUL/DIV engine sharing one bus.
module datapath_mc #(
   parameter int DATA_W  = 32,
   parameter int NUM_GPR = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_GPR-1:0]   gpr_in,
   input  logic [NUM_GPR-1:0]   gpr_out,
   input  logic                 hi_in,
   input  logic                 lo_in,
   input  logic                 pc_in,
   input  logic                 ir_in,
   input  logic                 y_in,
   input  logic                 mar_in,
   input  logic                 hi_out,
   input  logic                 lo_out,
   input  logic                 pc_out,
   input  logic                 mdr_out,
   input  logic                 z_high_out,
   input  logic                 z_low_out,
   input  logic                 z_in,
   input  logic                 pc_inc,
   input  logic                 mdr_in,
   input  logic                 read,
   input  logic [DATA_W-1:0]    m_data_in,
   input  logic [3:0]           alu_op,
   input  logic                 alu_start,
   output logic                 alu_busy,
   output logic                 alu_done,
   output logic                 div_zero,
   output logic                 bus_err,
   output logic [DATA_W-1:0]    bus_data,
   output logic [DATA_W-1:0]    mar_addr,
   output logic [DATA_W-1:0]    ir_data
);

   // state | meaning
   // IDLE  | no iterative op; z_in and alu_start accepted
   // RUN   | MUL/DIV stepping, one bit per cycle (cnt 0..DATA_W-1)
   // DONE  | result in Z, alu_done pulse; a new start is accepted

   localparam int SHW  = $clog2(DATA_W);
   localparam int NSEL = NUM_GPR + 6;
   localparam logic [3:0] OP_MUL = 4'd11;
   localparam logic [3:0] OP_DIV = 4'd12;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t                state_q, state_d;
   logic [SHW-1:0]        cnt_q;
   logic [DATA_W-1:0]     gpr_q [NUM_GPR];
   logic [DATA_W-1:0]     pc_q, ir_q, y_q, mar_q, mdr_q, hi_q, lo_q;
   logic [2*DATA_W-1:0]   z_q;

   // ---------------- shared bus ----------------
   logic [NSEL-1:0]       drv_sel;
   logic [DATA_W-1:0]     bus_mux;

   assign drv_sel = {z_low_out, z_high_out, mdr_out, pc_out, lo_out, hi_out, gpr_out};

   always_comb begin
      bus_mux = '0;
      for (int i = 0; i < NUM_GPR; i++) begin
         if (gpr_out[i]) bus_mux = bus_mux | gpr_q[i];
      end
      if (hi_out)     bus_mux = bus_mux | hi_q;
      if (lo_out)     bus_mux = bus_mux | lo_q;
      if (pc_out)     bus_mux = bus_mux | pc_q;
      if (mdr_out)    bus_mux = bus_mux | mdr_q;
      if (z_high_out) bus_mux = bus_mux | z_q[2*DATA_W-1:DATA_W];
      if (z_low_out)  bus_mux = bus_mux | z_q[DATA_W-1:0];
   end

   // Clearing the lowest set bit leaves something only when two or more selects are set.
   assign bus_err  = |(drv_sel & (drv_sel - NSEL'(1)));
   assign bus_data = bus_err ? '0 : bus_mux;
   assign mar_addr = mar_q;
   assign ir_data  = ir_q;

   // ---------------- single-cycle ALU ----------------
   logic [DATA_W-1:0]     alu_a, alu_b, alu_res;
   logic [SHW-1:0]        sh, sh_inv;

   assign alu_a  = y_q;
   assign alu_b  = bus_data;
   assign sh     = alu_b[SHW-1:0];
   assign sh_inv = SHW'(0) - sh;

   always_comb begin
      alu_res = '0;
      case (alu_op)
         4'd0:    alu_res = alu_a + alu_b;
         4'd1:    alu_res = alu_a - alu_b;
         4'd2:    alu_res = alu_a & alu_b;
         4'd3:    alu_res = alu_a | alu_b;
         4'd4:    alu_res = alu_a >> sh;
         4'd5:    alu_res = DATA_W'($signed(alu_a) >>> sh);
         4'd6:    alu_res = alu_a << sh;
         4'd7:    alu_res = (alu_a >> sh) | (alu_a << sh_inv);
         4'd8:    alu_res = (alu_a << sh) | (alu_a >> sh_inv);
         4'd9:    alu_res = -alu_b;
         4'd10:   alu_res = ~alu_b;
         4'd13:   alu_res = alu_b;
         default: alu_res = '0;
      endcase
   end

   // ---------------- iterative MUL/DIV engine ----------------
   // acc holds {upper W+1, lower W}: product/multiplier for MUL, remainder/quotient for DIV.
   logic [2*DATA_W:0]     acc_q;
   logic [DATA_W-1:0]     opnd_q;
   logic                  is_div_q, neg_q_q, neg_r_q, dz_q, div_zero_q;

   logic                  op_iter, start_ok;
   logic [DATA_W-1:0]     mag_a, mag_b;
   logic [DATA_W:0]       mul_sum, rem_s;
   logic [2*DATA_W:0]     mul_next, div_next, step_next;
   logic [DATA_W-1:0]     q_mag, r_mag;
   logic [2*DATA_W-1:0]   prod, mul_res, div_res, fin_res;

   assign op_iter  = (alu_op == OP_MUL) || (alu_op == OP_DIV);
   assign start_ok = alu_start && op_iter && (state_q != ST_RUN);
   assign mag_a    = alu_a[DATA_W-1] ? -alu_a : alu_a;
   assign mag_b    = alu_b[DATA_W-1] ? -alu_b : alu_b;

   assign mul_sum  = acc_q[2*DATA_W:DATA_W] + {1'b0, (acc_q[0] ? opnd_q : {DATA_W{1'b0}})};
   assign mul_next = {1'b0, mul_sum, acc_q[DATA_W-1:1]};

   // Restoring division: shift in the next dividend bit, subtract when it fits.
   assign rem_s    = acc_q[2*DATA_W-1:DATA_W-1];
   assign div_next = (rem_s >= {1'b0, opnd_q}) ?
                     {rem_s - {1'b0, opnd_q}, acc_q[DATA_W-2:0], 1'b1} :
                     {rem_s, acc_q[DATA_W-2:0], 1'b0};

   assign step_next = is_div_q ? div_next : mul_next;

   assign prod    = step_next[2*DATA_W-1:0];
   assign mul_res = neg_q_q ? -prod : prod;
   assign q_mag   = step_next[DATA_W-1:0];
   assign r_mag   = step_next[2*DATA_W-1:DATA_W];
   assign div_res = {(neg_r_q ? -r_mag : r_mag), (neg_q_q ? -q_mag : q_mag)};
   assign fin_res = is_div_q ? div_res : mul_res;

   always_comb begin
      state_d  = state_q;
      alu_busy = 1'b0;
      alu_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_ok) state_d = ST_RUN;
         end
         ST_RUN: begin
            alu_busy = 1'b1;
            if (cnt_q == SHW'(DATA_W-1)) state_d = ST_DONE;
         end
         ST_DONE: begin
            alu_done = 1'b1;
            state_d  = start_ok ? ST_RUN : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign div_zero = div_zero_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         opnd_q     <= '0;
         is_div_q   <= 1'b0;
         neg_q_q    <= 1'b0;
         neg_r_q    <= 1'b0;
         dz_q       <= 1'b0;
         div_zero_q <= 1'b0;
         z_q        <= '0;
      end else begin
         state_q <= state_d;
         if (start_ok) begin
            cnt_q    <= '0;
            is_div_q <= (alu_op == OP_DIV);
            neg_r_q  <= alu_a[DATA_W-1];
            dz_q     <= (alu_b == '0);
            if (alu_op == OP_DIV) begin
               acc_q      <= {{(DATA_W+1){1'b0}}, mag_a};
               opnd_q     <= mag_b;
               // A zero divisor yields an unsigned all-ones quotient, never negated.
               neg_q_q    <= (alu_a[DATA_W-1] ^ alu_b[DATA_W-1]) && (alu_b != '0);
               div_zero_q <= 1'b0;
            end else begin
               acc_q   <= {{(DATA_W+1){1'b0}}, mag_b};
               opnd_q  <= mag_a;
               neg_q_q <= alu_a[DATA_W-1] ^ alu_b[DATA_W-1];
            end
         end else if (state_q == ST_RUN) begin
            cnt_q <= cnt_q + SHW'(1);
            acc_q <= step_next;
            if (cnt_q == SHW'(DATA_W-1)) begin
               z_q <= fin_res;
               if (is_div_q && dz_q) div_zero_q <= 1'b1;
            end
         end
         if (z_in && !op_iter && (state_q != ST_RUN)) begin
            z_q <= {{DATA_W{1'b0}}, alu_res};
         end
      end
   end

   // ---------------- bus-loaded registers ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
         pc_q  <= '0;
         ir_q  <= '0;
         y_q   <= '0;
         mar_q <= '0;
         mdr_q <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         for (int i = 0; i < NUM_GPR; i++) begin
            if (gpr_in[i]) gpr_q[i] <= bus_data;
         end
         if (hi_in)       hi_q  <= bus_data;
         if (lo_in)       lo_q  <= bus_data;
         if (ir_in)       ir_q  <= bus_data;
         if (y_in)        y_q   <= bus_data;
         if (mar_in)      mar_q <= bus_data;
         if (pc_in)       pc_q  <= bus_data;
         else if (pc_inc) pc_q  <= pc_q + DATA_W'(1);
         if (mdr_in)      mdr_q <= read ? m_data_in : bus_data;
      end
   end

endmodule
